// File: rtl/e2prom_bist.sv
// Built-in self test for a byte-addressed I2C EEPROM behind a command-level I2C master.
// Writes a data pattern over an address window (waiting out the write-cycle time before
// each write), reads the window back, and reports mismatch count and first failing address.
module e2prom_bist #(
    parameter logic [15:0] WR_WAIT_TIME = 16'd5000,
    parameter logic [15:0] START_ADDR   = 16'd0,
    parameter logic [15:0] NUM_BYTES    = 16'd256,
    parameter logic [1:0]  MAX_RETRY    = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    output logic        i2c_rh_wl,
    output logic        i2c_exec,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        rw_done,
    output logic        rw_result,
    output logic [15:0] err_cnt,
    output logic [15:0] fail_addr
);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_CMD, WR_RESP, RD_CMD, RD_RESP, FINISH
    } state_t;

    // Address arithmetic is modulo 2^16, so the window may wrap through 16'h0000.
    localparam logic [15:0] LAST_ADDR = START_ADDR + NUM_BYTES - 16'd1;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  pat_sel_q, pat_sel_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] fail_addr_q, fail_addr_d;
    logic        result_q, result_d;

    logic [7:0]  pat;
    logic [7:0]  lfsr_next;
    logic        is_last;
    logic        mismatch;
    logic [15:0] err_sat_inc;
    logic [15:0] err_new;

    // Expected/write data for the current address.
    always_comb begin
        unique case (pat_sel_q)
            2'd0:    pat = addr_q[7:0];
            2'd1:    pat = ~addr_q[7:0];
            2'd2:    pat = lfsr_q;
            default: pat = addr_q[0] ? 8'hAA : 8'h55;
        endcase
    end

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting toward the MSB.
    assign lfsr_next   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign is_last     = (addr_q == LAST_ADDR);
    assign err_sat_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 16'd0;
            pat_sel_q   <= 2'd0;
            lfsr_q      <= 8'd0;
            wait_cnt_q  <= 16'd0;
            retry_q     <= 2'd0;
            err_cnt_q   <= 16'd0;
            fail_addr_q <= NO_FAIL;
            result_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_sel_q   <= pat_sel_d;
            lfsr_q      <= lfsr_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_q     <= retry_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            result_q    <= result_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_sel_d   = pat_sel_q;
        lfsr_d      = lfsr_q;
        wait_cnt_d  = wait_cnt_q;
        retry_d     = retry_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        result_d    = result_q;
        mismatch    = 1'b0;
        err_new     = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_sel_d   = pattern_sel;
                    addr_d      = START_ADDR;
                    lfsr_d      = LFSR_SEED;
                    err_cnt_d   = 16'd0;
                    result_d    = 1'b0;
                    fail_addr_d = NO_FAIL;
                    retry_d     = 2'd0;
                    wait_cnt_d  = 16'd0;
                    state_d     = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if ({1'b0, wait_cnt_q} + 17'd1 >= {1'b0, WR_WAIT_TIME}) begin
                    wait_cnt_d = 16'd0;
                    state_d    = WR_CMD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            WR_CMD: state_d = WR_RESP;
            WR_RESP: begin
                if (i2c_done) begin
                    if (!i2c_ack) begin
                        retry_d = 2'd0;
                        if (is_last) begin
                            addr_d  = START_ADDR;
                            lfsr_d  = LFSR_SEED;
                            state_d = RD_CMD;
                        end else begin
                            addr_d  = addr_q + 16'd1;
                            lfsr_d  = lfsr_next;
                            state_d = WR_WAIT;
                        end
                    end else if (retry_q < MAX_RETRY) begin
                        // Same address and LFSR value, so the retry rewrites identical data.
                        retry_d = retry_q + 2'd1;
                        state_d = WR_WAIT;
                    end else begin
                        fail_addr_d = addr_q;
                        result_d    = 1'b0;
                        state_d     = FINISH;
                    end
                end
            end
            RD_CMD: state_d = RD_RESP;
            RD_RESP: begin
                if (i2c_done) begin
                    if (!i2c_ack) begin
                        retry_d  = 2'd0;
                        mismatch = (i2c_data_r != pat);
                        err_new  = mismatch ? err_sat_inc : err_cnt_q;
                        err_cnt_d = err_new;
                        if (mismatch && fail_addr_q == NO_FAIL) begin
                            fail_addr_d = addr_q;
                        end
                        if (is_last) begin
                            result_d = (err_new == 16'd0);
                            state_d  = FINISH;
                        end else begin
                            addr_d  = addr_q + 16'd1;
                            lfsr_d  = lfsr_next;
                            state_d = RD_CMD;
                        end
                    end else if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 2'd1;
                        state_d = RD_CMD;
                    end else begin
                        fail_addr_d = addr_q;
                        result_d    = 1'b0;
                        state_d     = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i2c_exec   = (state_q == WR_CMD) || (state_q == RD_CMD);
    assign i2c_rh_wl  = (state_q == RD_CMD) || (state_q == RD_RESP);
    assign i2c_addr   = addr_q;
    assign i2c_data_w = pat;
    assign busy       = (state_q != IDLE) && (state_q != FINISH);
    assign rw_done    = (state_q == FINISH);
    assign rw_result  = result_q;
    assign err_cnt    = err_cnt_q;
    assign fail_addr  = fail_addr_q;

endmodule

// File: tb/tb_e2prom_bist.sv
// Scoreboard bench for e2prom_bist: a four-byte window wrapping through 16'h0000,
// a behavioural I2C slave with injectable NACKs and read corruption.
module tb_e2prom_bist;

    localparam logic [15:0] WAIT = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        i2c_rh_wl, i2c_exec;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r = 8'd0;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;
    logic        busy, rw_done, rw_result;
    logic [15:0] err_cnt, fail_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    e2prom_bist #(
        .WR_WAIT_TIME(WAIT),
        .START_ADDR  (16'hFFFE),
        .NUM_BYTES   (16'd4),
        .MAX_RETRY   (2'd2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_sel(pattern_sel),
        .i2c_rh_wl  (i2c_rh_wl),
        .i2c_exec   (i2c_exec),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .i2c_data_r (i2c_data_r),
        .i2c_done   (i2c_done),
        .i2c_ack    (i2c_ack),
        .busy       (busy),
        .rw_done    (rw_done),
        .rw_result  (rw_result),
        .err_cnt    (err_cnt),
        .fail_addr  (fail_addr)
    );

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [32:0] res_q[$];   // {rw_result, err_cnt, fail_addr}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [15:0] a, input logic [7:0] d);
        cmd_t c;
        c.rd = 1'b0; c.addr = a; c.data = d;
        cmd_q.push_back(c);
    endtask

    task automatic push_r(input logic [15:0] a);
        cmd_t c;
        c.rd = 1'b1; c.addr = a; c.data = 8'h00;
        cmd_q.push_back(c);
    endtask

    task automatic push_reads();
        push_r(16'hFFFE); push_r(16'hFFFF); push_r(16'h0000); push_r(16'h0001);
    endtask

    // Slave: responds two falling edges after seeing a command.
    logic [7:0]  mem [256];
    bit          corrupt [256];
    logic [15:0] nack_addr = 16'd0;
    logic        nack_rd = 1'b0;
    int          nack_left = 0;

    initial begin
        int          pend;
        logic        s_rd;
        logic [15:0] s_addr;
        logic [7:0]  s_data;
        pend = 0; s_rd = 1'b0; s_addr = 16'd0; s_data = 8'd0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i2c_done = 1'b1;
                    if (nack_left > 0 && nack_addr == s_addr && nack_rd == s_rd) begin
                        i2c_ack = 1'b1;
                        nack_left--;
                    end else if (s_rd) begin
                        i2c_data_r = mem[s_addr[7:0]] ^ (corrupt[s_addr[7:0]] ? 8'hFF : 8'h00);
                    end else begin
                        mem[s_addr[7:0]] = s_data;
                    end
                end
            end
            if (i2c_exec && !rst) begin
                s_rd = i2c_rh_wl; s_addr = i2c_addr; s_data = i2c_data_w; pend = 2;
            end
        end
    end

    // Monitor: pops expected commands on every exec and expected results on every rw_done.
    initial begin
        int   cyc, last_evt;
        bit   open, last_wr, busy_prev;
        cmd_t e;
        logic [32:0] r;
        cyc = 0; last_evt = 0; open = 0; last_wr = 0; busy_prev = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                open = 0; busy_prev = 0;
                continue;
            end
            if (busy && !busy_prev) last_evt = cyc;
            busy_prev = busy;
            if (i2c_done) begin
                open = 0;
                if (last_wr) last_evt = cyc;
            end
            if (i2c_exec) begin
                check("exec_without_done", 64'(open), 64'(0));
                open = 1;
                last_wr = !i2c_rh_wl;
                if (cmd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_exec: got rd=%b addr=%h, expected no command",
                             i2c_rh_wl, i2c_addr);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_dir", 64'(i2c_rh_wl), 64'(e.rd));
                    check("cmd_addr", 64'(i2c_addr), 64'(e.addr));
                    if (!e.rd) begin
                        check("wr_data", 64'(i2c_data_w), 64'(e.data));
                        check("wr_wait_gap", 64'(cyc - last_evt), 64'(WAIT));
                    end
                end
            end
            if (rw_done) begin
                check("busy_at_done", 64'(busy), 64'(0));
                if (res_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_rw_done: got rw_done=1, expected none");
                end else begin
                    r = res_q.pop_front();
                    check("run_result", 64'({rw_result, err_cnt, fail_addr}), 64'(r));
                end
            end
        end
    end

    task automatic start_run(input logic [1:0] sel);
        @(negedge clk);
        pattern_sel = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(posedge clk); #1;
            if (rw_done) seen = 1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL run_timeout: got no rw_done, expected rw_done within 2000 cycles");
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_slave();
        for (int i = 0; i < 256; i++) corrupt[i] = 0;
        nack_left = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_exec", 64'(i2c_exec), 64'(0));
        check("rst_rh_wl", 64'(i2c_rh_wl), 64'(0));
        check("rst_addr", 64'(i2c_addr), 64'(0));
        check("rst_data_w", 64'(i2c_data_w), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rw_done", 64'(rw_done), 64'(0));
        check("rst_rw_result", 64'(rw_result), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_fail_addr", 64'(fail_addr), 64'(16'hFFFF));
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_slave();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Pattern 0 with a stray start mid-run that must be ignored.
        push_w(16'hFFFE, 8'hFE); push_w(16'hFFFF, 8'hFF);
        push_w(16'h0000, 8'h00); push_w(16'h0001, 8'h01);
        push_reads();
        res_q.push_back({1'b1, 16'h0000, 16'hFFFF});
        start_run(2'd0);
        repeat (10) @(negedge clk);
        pattern_sel = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Pattern 1, reads of 0000 and 0001 corrupted.
        clear_slave();
        corrupt[8'h00] = 1; corrupt[8'h01] = 1;
        push_w(16'hFFFE, 8'h01); push_w(16'hFFFF, 8'h00);
        push_w(16'h0000, 8'hFF); push_w(16'h0001, 8'hFE);
        push_reads();
        res_q.push_back({1'b0, 16'h0002, 16'h0000});
        start_run(2'd1);
        wait_done();

        // Pattern 2, one write NACK at 0000: LFSR must hold for the retry.
        clear_slave();
        nack_addr = 16'h0000; nack_rd = 1'b0; nack_left = 1;
        push_w(16'hFFFE, 8'hA5); push_w(16'hFFFF, 8'h4A);
        push_w(16'h0000, 8'h95); push_w(16'h0000, 8'h95); push_w(16'h0001, 8'h2A);
        push_reads();
        res_q.push_back({1'b1, 16'h0000, 16'hFFFF});
        start_run(2'd2);
        wait_done();

        // Pattern 3, two write NACKs at FFFF then ACK: run passes.
        clear_slave();
        nack_addr = 16'hFFFF; nack_rd = 1'b0; nack_left = 2;
        push_w(16'hFFFE, 8'h55);
        push_w(16'hFFFF, 8'hAA); push_w(16'hFFFF, 8'hAA); push_w(16'hFFFF, 8'hAA);
        push_w(16'h0000, 8'h55); push_w(16'h0001, 8'hAA);
        push_reads();
        res_q.push_back({1'b1, 16'h0000, 16'hFFFF});
        start_run(2'd3);
        wait_done();

        // Pattern 3, three write NACKs at 0000: abort.
        clear_slave();
        nack_addr = 16'h0000; nack_rd = 1'b0; nack_left = 3;
        push_w(16'hFFFE, 8'h55); push_w(16'hFFFF, 8'hAA);
        push_w(16'h0000, 8'h55); push_w(16'h0000, 8'h55); push_w(16'h0000, 8'h55);
        res_q.push_back({1'b0, 16'h0000, 16'h0000});
        start_run(2'd3);
        wait_done();

        // Pattern 0, corrupt FFFE then read abort at 0000 overwrites fail_addr.
        clear_slave();
        corrupt[8'hFE] = 1;
        nack_addr = 16'h0000; nack_rd = 1'b1; nack_left = 3;
        push_w(16'hFFFE, 8'hFE); push_w(16'hFFFF, 8'hFF);
        push_w(16'h0000, 8'h00); push_w(16'h0001, 8'h01);
        push_r(16'hFFFE); push_r(16'hFFFF);
        push_r(16'h0000); push_r(16'h0000); push_r(16'h0000);
        res_q.push_back({1'b0, 16'h0001, 16'h0000});
        start_run(2'd0);
        wait_done();

        // Reset during the read phase: no rw_done, outputs back to reset values.
        clear_slave();
        push_w(16'hFFFE, 8'hFE); push_w(16'hFFFF, 8'hFF);
        push_w(16'h0000, 8'h00); push_w(16'h0001, 8'h01);
        push_r(16'hFFFE); push_r(16'hFFFF);
        start_run(2'd0);
        found = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(posedge clk); #1;
            if (i2c_exec && i2c_rh_wl && i2c_addr == 16'hFFFF) found = 1;
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL rd_phase_timeout: got no read of FFFF, expected one within 2000 cycles");
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // Fresh run after reset, pattern 1, clean slave.
        push_w(16'hFFFE, 8'h01); push_w(16'hFFFF, 8'h00);
        push_w(16'h0000, 8'hFF); push_w(16'h0001, 8'hFE);
        push_reads();
        res_q.push_back({1'b1, 16'h0000, 16'hFFFF});
        start_run(2'd1);
        wait_done();

        check("cmd_queue_left", 64'(cmd_q.size()), 64'(0));
        check("result_queue_left", 64'(res_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/e2prom_bist.md
E2PROM_BIST -- requirements
Module: e2prom_bist

Interface
REQ-001 Parameter WR_WAIT_TIME, default 16'd5000: idle clocks inserted before every write command (EEPROM write-cycle time).
REQ-002 Parameter START_ADDR, default 16'd0: first device address tested.
REQ-003 Parameter NUM_BYTES, default 16'd256, legal range 1..65535: number of consecutive bytes tested.
REQ-004 Parameter MAX_RETRY, default 2'd2: re-issues allowed per command after a NACK.
REQ-005 clk  input  1  single clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse; begins a test run; ignored unless idle.
REQ-008 pattern_sel  input  2  data pattern, sampled on accepted start.
REQ-009 i2c_rh_wl  output  1  1=read, 0=write.
REQ-010 i2c_exec  output  1  one-cycle command trigger.
REQ-011 i2c_addr  output  16  device byte address.
REQ-012 i2c_data_w  output  8  write data.
REQ-013 i2c_data_r  input  8  read data, valid with i2c_done.
REQ-014 i2c_done  input  1  one-cycle command-complete pulse.
REQ-015 i2c_ack  input  1  valid with i2c_done; 1 = NACK.
REQ-016 busy  output  1  high from accepted start until rw_done.
REQ-017 rw_done  output  1  one-cycle pulse at end of run.
REQ-018 rw_result  output  1  1=pass, 0=fail; held until next accepted start.
REQ-019 err_cnt  output  16  mismatching bytes this run, saturating at 16'hFFFF.
REQ-020 fail_addr  output  16  address of first mismatch or NACK abort; 16'hFFFF if none.

Function
REQ-021 States: IDLE, WR_WAIT, WR_CMD, WR_RESP, RD_CMD, RD_RESP, FINISH.
REQ-022 IDLE + start: latch pattern_sel; i2c_addr=START_ADDR; clear err_cnt, rw_result; fail_addr=16'hFFFF; busy=1; retry count=0; -> WR_WAIT.
REQ-023 WR_WAIT: count WR_WAIT_TIME clocks, then -> WR_CMD; counter width 16 bits.
REQ-024 WR_CMD: i2c_rh_wl=0, i2c_data_w=pattern(addr), i2c_exec=1 for exactly one cycle; -> WR_RESP.
REQ-025 Patterns: 0 = addr[7:0]; 1 = ~addr[7:0]; 2 = 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed 8'hA5 at START_ADDR, advanced once per byte; 3 = 8'h55 when addr[0]=0, else 8'hAA.
REQ-026 Pattern 2 read phase re-seeds to 8'hA5 so expected data match written data byte for byte.
REQ-027 WR_RESP on i2c_done with ack=0: if last byte (addr == START_ADDR+NUM_BYTES-1, modulo 2^16) -> RD_CMD with addr=START_ADDR; else addr+1 -> WR_WAIT; retry count cleared.
REQ-028 Address increment wraps 16'hFFFF -> 16'h0000.
REQ-029 RD_CMD: i2c_rh_wl=1, i2c_exec=1 one cycle, no wait; -> RD_RESP.
REQ-030 RD_RESP on i2c_done with ack=0: compare i2c_data_r to pattern; on mismatch increment err_cnt (saturating) and record fail_addr if still 16'hFFFF; run continues.
REQ-031 RD_RESP: after last byte -> FINISH; else addr+1 -> RD_CMD.
REQ-032 NACK (ack=1 with i2c_done) in WR_RESP or RD_RESP: if retry count < MAX_RETRY, increment it and reissue same address/data (writes via WR_WAIT, reads via RD_CMD); else abort: fail_addr=current addr (overwrites), -> FINISH.
REQ-033 FINISH: rw_done=1 one cycle; rw_result=1 only if err_cnt=0 and no abort; busy=0; -> IDLE.
REQ-034 i2c_done outside WR_RESP/RD_RESP is ignored; start while busy is ignored.
REQ-035 Exactly one i2c_exec per issued command; never two exec without an intervening i2c_done.

Reset
REQ-036 rst sampled on clk: state=IDLE; all outputs 0 except fail_addr=16'hFFFF; internal counters 0; applies mid-run, discarding the run with no rw_done.

Verification
REQ-037 Defaults, pattern 0, ideal slave model: 256 writes each preceded by 5000 idle clocks, 256 reads, rw_done pulse, rw_result=1, err_cnt=0, fail_addr=FFFF.
REQ-038 Pattern 2, NUM_BYTES=4: write data A5 then next three LFSR values; reads returning same -> pass.
REQ-039 Slave corrupts byte at addr 0x10 and 0x20 -> err_cnt=2, fail_addr=0x0010, rw_result=0, all 256 reads still issued.
REQ-040 NACK twice on write addr 5, then ACK -> three exec at addr 5, run passes; NACK three times -> abort, fail_addr=0x0005, rw_result=0.
REQ-041 START_ADDR=16'hFFFE, NUM_BYTES=4 -> addresses FFFE, FFFF, 0000, 0001 in both phases.
REQ-042 rst asserted during read phase -> next cycle all outputs at reset values, no rw_done; new start runs normally.
